// File: rtl/fetch_pkg.sv
// Shared fetch-stage types, constants and helpers.
// Imported by fetch_fifo and inst_fetch_queue.
package fetch_pkg;

  localparam int FETCH_W = 32;
  localparam logic [FETCH_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with push/pop/clear.
// Head output holds the last popped entry while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  fetch_entry_t           din,
  input  logic                   pop,
  input  logic                   clear,
  output fetch_entry_t           head,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty && !clear;
  assign do_push   = push && !clear &&
                     ((count != FULL) || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : last;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE;
        last   <= mem[rd_ptr];
      end
      count <= count + (PW+1)'(do_push)
                     - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC, credit-based inst_mem issue, prefetch queue.
// Optional FETCH_PERF_EN adds saturating perf counters.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_en,
  input  logic [31:0]            mem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall,
  output logic [31:0]            perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [31:0]  fetch_pc;
  logic [31:0]  issue_pc;
  logic         inflight;
  logic         push;
  logic         pop;
  logic         head_valid;
  logic [CW:0]  credit;
  fetch_entry_t din;
  fetch_entry_t head;

  // In-flight read holds a slot so its return never overflows.
  assign credit    = {1'b0, occupancy} + (CW+1)'(inflight);
  assign mem_en    = RST && !redirect && (credit < CREDIT_MAX);
  assign mem_addr  = fetch_pc[ADDR_W+1:2];
  assign push      = inflight && !redirect;
  assign out_valid = head_valid && !redirect;
  assign pop       = out_valid && out_ready;
  assign din       = '{pc: issue_pc, inst: mem_rdata};
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .din      (din),
    .pop      (pop),
    .clear    (redirect),
    .head     (head),
    .not_empty(head_valid),
    .count    (occupancy)
  );

  // Clearing inflight on redirect kills the read still returning.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc <= RESET_PC;
      issue_pc <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_en;
      if (mem_en) begin
        issue_pc <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, push);
      perf_stall   <= sat_inc(perf_stall,
                              out_valid && !out_ready);
      perf_flush   <= sat_inc(perf_flush, redirect);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a 1-cycle memory model.
// Perf checks run when FETCH_PERF_EN is defined.
module tb_inst_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  mem_addr;
  logic        mem_en;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int   errors = 0;
  int   checks = 0;
  bit   sb_on = 1'b0;
  exp_t sb[$];
  exp_t e;

  inst_fetch_queue #(
    .DEPTH(4),
    .ADDR_W(6),
    .RESET_PC(32'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .occupancy  (occupancy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory word n holds 0x1000_0000 + n.
  always @(posedge CLK) begin
    if (mem_en) mem_rdata <= 32'h1000_0000 + 32'(mem_addr);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] base);
    logic [31:0] pc;
    sb.delete();
    for (int i = 0; i < 128; i++) begin
      pc = base + 32'(4 * i);
      sb.push_back('{pc: pc,
        inst: 32'h1000_0000 + ((pc >> 2) & 32'h3F)});
    end
  endtask

  always @(negedge CLK) begin
    if (sb_on && RST) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_pop", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_inst", out_inst, e.inst);
        end
      end else if (out_valid && sb.size() != 0) begin
        check("hold_pc", out_pc, sb[0].pc);
      end
    end
  end

  initial begin
    #1 RST = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);

    // Cold start: first valid in cycle 2, then one per cycle.
    @(posedge CLK); #1;
    RST = 1'b1;
    sb_load(32'h0);
    sb_on = 1'b1;
    @(negedge CLK);
    check("c0_mem_en", 32'(mem_en), 32'd1);
    check("c0_addr", 32'(mem_addr), 32'd0);
    @(negedge CLK);
    check("c1_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("c2_pc", out_pc, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", 32'(out_valid), 32'd1);
      @(negedge CLK);
    end

    // Back-pressure fills the queue.
    @(posedge CLK); #1;
    out_ready = 1'b0;
    repeat (10) @(negedge CLK);
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_mem_en", 32'(mem_en), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    repeat (8) @(negedge CLK);

    // Redirect while three entries are queued.
    @(posedge CLK); #1;
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    sb_load(32'h80);
    @(posedge CLK); #1;
    redirect = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    out_ready   = 1'b1;
    sb_load(32'h40);
    @(negedge CLK);
    check("rd_occ3", 32'(occupancy), 32'd3);
    check("rd_valid", 32'(out_valid), 32'd0);
    check("rd_mem_en", 32'(mem_en), 32'd0);
    @(posedge CLK); #1;
    redirect = 1'b0;
    @(negedge CLK);
    check("rd_occ0", 32'(occupancy), 32'd0);
    check("rd_issue", 32'(mem_en), 32'd1);
    check("rd_addr", 32'(mem_addr), 32'd16);
    @(negedge CLK);
    check("rd_lat", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("rd_first", out_pc, 32'h40);
    repeat (4) @(negedge CLK);

    // Unaligned target is forced to a word boundary.
    @(posedge CLK); #1;
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    sb_load(32'h40);
    @(posedge CLK); #1;
    redirect = 1'b0;
    @(negedge CLK);
    check("align_addr", 32'(mem_addr), 32'd16);
    repeat (5) @(negedge CLK);

    // Back-to-back redirects: the last one wins.
    @(posedge CLK); #1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(posedge CLK); #1;
    redirect_pc = 32'h20C;
    sb_load(32'h20C);
    @(posedge CLK); #1;
    redirect = 1'b0;
    @(negedge CLK);
    check("b2b_addr", 32'(mem_addr), 32'd3);
    repeat (6) @(negedge CLK);

    // Asynchronous reset mid-stream.
    @(negedge CLK);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    RST   = 1'b0;
    sb_on = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_mem_en", 32'(mem_en), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    sb_load(32'h0);
    sb_on = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("re_c1_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("re_c2_valid", 32'(out_valid), 32'd1);
    check("re_c2_pc", out_pc, 32'd0);
    repeat (4) @(negedge CLK);

`ifdef FETCH_PERF_EN
    @(posedge CLK); #1;
    RST   = 1'b0;
    sb_on = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    sb_load(32'h0);
    sb_on = 1'b1;
    repeat (7) @(negedge CLK);
    check("perf_fetched", perf_fetched, 32'd5);
    @(posedge CLK); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    out_ready = 1'b1;
    @(negedge CLK);
    check("perf_stall", perf_stall, 32'd5);
    @(posedge CLK); #1;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    sb_load(32'h0);
    @(posedge CLK); #1;
    redirect = 1'b0;
    @(posedge CLK); #1;
    redirect = 1'b1;
    @(posedge CLK); #1;
    redirect = 1'b0;
    @(negedge CLK);
    check("perf_flush", perf_flush, 32'd2);
    check("perf_stall2", perf_stall, 32'd5);
    repeat (4) @(negedge CLK);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
